// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/farm-road traffic light controller.
//   - lamp_t  : 2-bit lamp drive code (RED/YELLOW/GREEN; 2'b11 never driven)
//   - state_t : controller state codes, also exported on o_state for debug
//   - hwy_lamp/farm_lamp : lamp decode for each state
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } lamp_t;

  typedef enum logic [1:0] {
    HG = 2'b00,  // highway GREEN, farm RED
    HY = 2'b01,  // highway YELLOW, farm RED
    FG = 2'b10,  // highway RED, farm GREEN
    FY = 2'b11   // highway RED, farm YELLOW
  } state_t;

  function automatic lamp_t hwy_lamp(input state_t s);
    case (s)
      HG:      hwy_lamp = GREEN;
      HY:      hwy_lamp = YELLOW;
      default: hwy_lamp = RED;
    endcase
  endfunction

  function automatic lamp_t farm_lamp(input state_t s);
    case (s)
      FG:      farm_lamp = GREEN;
      FY:      farm_lamp = YELLOW;
      default: farm_lamp = RED;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge.sv
// N-flop synchronizer with a rising-edge detector on the synchronized level.
// Ports:
//   clk   - sampling clock
//   rst   - asynchronous active-high reset, clears all flops
//   d     - asynchronous input level
//   level - synchronized level (output of the last synchronizer flop)
//   rise  - high for one clk cycle after level goes 0->1
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  // Fewer than two flops gives no metastability protection, so clamp.
  localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sr;
  logic         prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[N-2:0], d};
      prev <= sr[N-1];
    end
  end

  assign level = sr[N-1];
  assign rise  = sr[N-1] & ~prev;

endmodule

// File: rtl/traffic_light_controller.sv
// Highway / farm-road traffic light controller.
// The highway stays green until the long interval has expired AND a farm-road
// car has been seen; the farm road stays green until the long interval expires
// or no car remains. Yellow phases last one short interval. Start pulses drive
// an external timing circuit that reports expiry on i_long_timer/i_short_timer.
// Ports:
//   i_clk, i_reset              - clock, asynchronous active-high reset
//   i_car_sensor                - farm-road vehicle present (async level)
//   i_long_timer, i_short_timer - interval expiry from the timing circuit (async)
//   o_long_start, o_short_start - one-cycle interval start pulses (registered)
//   o_highway_light, o_farm_light - lamp codes (registered)
//   o_state                     - current state code (debug)
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_car_sensor,
  input  logic       i_long_timer,
  input  logic       i_short_timer,
  output logic       o_long_start,
  output logic       o_short_start,
  output logic [1:0] o_highway_light,
  output logic [1:0] o_farm_light,
  output logic [1:0] o_state
);

  logic car_level, car_rise;
  logic long_level, long_evt;
  logic short_level, short_evt;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_car (
    .clk   (i_clk),
    .rst   (i_reset),
    .d     (i_car_sensor),
    .level (car_level),
    .rise  (car_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_long (
    .clk   (i_clk),
    .rst   (i_reset),
    .d     (i_long_timer),
    .level (long_level),
    .rise  (long_evt)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_short (
    .clk   (i_clk),
    .rst   (i_reset),
    .d     (i_short_timer),
    .level (short_level),
    .rise  (short_evt)
  );

  // The FSM needs only the car level and the timer edges.
  logic unused_sync;
  assign unused_sync = &{1'b0, car_rise, long_level, short_level};

  state_t state, state_next;
  logic   long_expired, long_expired_next;
  logic   car_pending, car_pending_next;
  logic   init_pending;  // set by reset: first edge afterwards starts the HG interval
  logic   long_start_next, short_start_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= HG;
      long_expired    <= 1'b0;
      car_pending     <= 1'b0;
      init_pending    <= 1'b1;
      o_long_start    <= 1'b0;
      o_short_start   <= 1'b0;
      o_highway_light <= GREEN;
      o_farm_light    <= RED;
    end else begin
      state           <= state_next;
      long_expired    <= long_expired_next;
      car_pending     <= car_pending_next;
      init_pending    <= 1'b0;
      o_long_start    <= long_start_next;
      o_short_start   <= short_start_next;
      o_highway_light <= hwy_lamp(state_next);
      o_farm_light    <= farm_lamp(state_next);
    end
  end

  // Only the event belonging to the current state is examined, so a
  // coincident event for another state is dropped.
  always_comb begin
    state_next        = state;
    long_expired_next = long_expired;
    car_pending_next  = car_pending;
    long_start_next   = 1'b0;
    short_start_next  = 1'b0;
    if (init_pending) begin
      state_next      = HG;
      long_start_next = 1'b1;
    end else begin
      case (state)
        HG: begin
          car_pending_next = car_pending | car_level;
          if ((long_expired | long_evt) && (car_pending | car_level)) begin
            state_next        = HY;
            short_start_next  = 1'b1;
            long_expired_next = 1'b0;
          end else if (long_evt) begin
            long_expired_next = 1'b1;
          end
        end
        HY: begin
          car_pending_next = car_pending | car_level;
          if (short_evt) begin
            state_next       = FG;
            long_start_next  = 1'b1;
            car_pending_next = 1'b0;
          end
        end
        FG: begin
          if (long_evt || !car_level) begin
            state_next       = FY;
            short_start_next = 1'b1;
          end
        end
        FY: begin
          if (short_evt) begin
            state_next      = HG;
            long_start_next = 1'b1;
          end
        end
        default: begin
          state_next        = HG;
          long_start_next   = 1'b1;
          long_expired_next = 1'b0;
        end
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: doc/traffic_light_controller.md
TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each asynchronous input (minimum 2).
REQ-002 SHALL have port i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_car_sensor  input  1  farm-road vehicle present (asynchronous level).
REQ-005 SHALL have port i_long_timer  input  1  long-interval expiry from the timing circuit (may come from its divided-clock domain).
REQ-006 SHALL have port i_short_timer  input  1  short-interval expiry from the timing circuit.
REQ-007 SHALL have port o_long_start  output  1  one-cycle pulse that starts the long interval; drives the timing circuit's i_Long_time.
REQ-008 SHALL have port o_short_start  output  1  one-cycle pulse that starts the short interval; drives the timing circuit's i_Short_time.
REQ-009 SHALL have port o_highway_light  output  2  highway lamp: 00 RED, 01 YELLOW, 10 GREEN; 11 is never driven.
REQ-010 SHALL have port o_farm_light  output  2  farm-road lamp, same encoding.
REQ-011 SHALL have port o_state  output  2  current state code, for debug.

Function
REQ-012 SHALL pass i_car_sensor, i_long_timer and i_short_timer each through SYNC_STAGES flops before use.
REQ-013 SHALL form long_evt and short_evt as rising edges of the synchronized timer inputs; a level held high produces exactly one event.
REQ-014 SHALL implement states HG=00 (hwy GREEN/farm RED), HY=01 (YELLOW/RED), FG=10 (RED/GREEN), FY=11 (RED/YELLOW).
REQ-015 SHALL latch long_expired on long_evt in HG and clear it when leaving HG.
REQ-016 SHALL latch car_pending while the synchronized sensor is high in HG or HY and clear it when entering FG.
REQ-017 SHALL go HG->HY when long_expired (or long_evt this cycle) and (car_pending or synchronized sensor) are both true, and pulse o_short_start.
REQ-018 SHALL stay in HG indefinitely with no car; if long_expired is already set, a car arriving SHALL cause HG->HY on the first cycle the synchronized sensor is high.
REQ-019 SHALL go HY->FG on short_evt and pulse o_long_start.
REQ-020 SHALL go FG->FY on long_evt or when the synchronized sensor is low, and pulse o_short_start.
REQ-021 SHALL go FY->HG on short_evt and pulse o_long_start.
REQ-022 SHALL register all outputs; lamps, o_state and the start pulse change on the same edge as the state transition, with 1-cycle latency from the synchronized event.
REQ-023 SHALL act only on the event belonging to the current state when long_evt and short_evt coincide; the other event is discarded.
REQ-024 SHALL keep each start pulse exactly one i_clk cycle wide and never assert both start pulses in the same cycle.
REQ-025 SHALL never drive GREEN or YELLOW on both roads at once.

Reset
REQ-026 SHALL on i_reset, immediately and asynchronously, force state HG, hwy GREEN, farm RED, both start pulses 0, synchronizers and flags 0, even mid-operation.
REQ-027 SHALL pulse o_long_start on the first rising edge after i_reset deasserts, to start the initial HG interval.
REQ-028 SHALL treat an unreachable state as HG and pulse o_long_start.

Structure
REQ-029 SHALL take the lamp encodings (RED, YELLOW, GREEN) and state codes from a shared package, traffic_pkg.
REQ-030 SHALL contain one sub-module, sync_edge (an N-flop synchronizer with a rising-edge output), instantiated three times.

Verification
REQ-031 Reset release -> o_long_start=1 for one cycle at the first edge; lamps 10/00; o_state=00.
REQ-032 Sensor held 1, then long_timer pulse -> after SYNC_STAGES+1 cycles: o_short_start pulses, lamps 01/00; short_timer pulse -> lamps 00/10 and o_long_start pulses.
REQ-033 Long expiry with sensor 0 -> remain HG with no start pulses; later sensor 1 -> HY within SYNC_STAGES+1 cycles.
REQ-034 In FG, sensor drops to 0 before long expiry -> FY with an o_short_start pulse; short_timer pulse -> HG with an o_long_start pulse.
REQ-035 In HY, long and short timers rise in the same cycle -> FG only, one o_long_start pulse; in HG, a held-high i_long_timer -> a single event.
REQ-036 i_reset asserted in FY -> lamps 10/00 and o_state=00 with no clock edge, no start pulse until reset is released.
